// File: rtl/if_fetch.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// if_fetch -- instruction-fetch stage of the 5-stage RISC-V pipeline.
//
// Owns the fetch PC and drives a variable-latency req/ack instruction memory.
// It presents at most one instruction per cycle to the IF/ID register. It
// honours the IF/ID hold (PC_lock) by parking one returned word in a skid
// register. It honours redirects (ControlChange) by flushing the slot and
// discarding any fetch that is still in flight.
//
// Optional feature macro: IF_MISALIGN_CHECK_EN
//   defined   : a redirect to a target with PC_target[1:0] != 0 parks the
//               stage in FAULT and raises fetch_misalign.
//   undefined : PC_target[1:0] is forced to 2'b00, fetch_misalign is tied
//               low, and the FAULT state does not exist.
//
// Parameters
//   RESET_PC       first fetch address after reset
//   NOP_INST       instruction presented while the slot is empty
// Ports
//   clk            clock, rising edge
//   rst            asynchronous reset, active low
//   ControlChange  redirect request; fetch resumes at PC_target
//   PC_target      redirect address
//   PC_lock        IF/ID hold: the presented slot is not consumed this cycle
//   imem_req       fetch request valid
//   imem_addr      fetch address, stable from request until ack
//   imem_ack       response strobe, imem_rdata valid in the same cycle
//   imem_rdata     fetched instruction word
//   PC_out         PC of the presented instruction (0 when empty)
//   inst_out       presented instruction (NOP_INST when empty)
//   inst_valid     PC_out/inst_out hold a real fetched instruction
//   fetch_misalign misaligned-redirect fault flag
// ---------------------------------------------------------------------------
// state | meaning
// FETCH | request outstanding at fetch_pc; returned word goes to slot or skid
// SKID  | slot full and held, one extra word parked in skid; no request
// DROP  | redirect arrived mid-request; wait for that ack and discard the data
// FAULT | misaligned redirect target; idle until an aligned redirect
// ---------------------------------------------------------------------------
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ControlChange,
  input  logic [31:0] PC_target,
  input  logic        PC_lock,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_out,
  output logic [31:0] inst_out,
  output logic        inst_valid,
  output logic        fetch_misalign
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    SKID  = 2'd1,
    DROP  = 2'd2
`ifdef IF_MISALIGN_CHECK_EN
    , FAULT = 2'd3
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] drop_addr_q, drop_addr_d;
  logic        slot_valid_q, slot_valid_d;
  logic [31:0] slot_pc_q, slot_pc_d;
  logic [31:0] slot_inst_q, slot_inst_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_inst_q, skid_inst_d;

  logic        slot_consumed;
  logic        slot_free;
  logic [31:0] redirect_pc;
  state_t      redirect_state;

`ifdef IF_MISALIGN_CHECK_EN
  logic        target_misaligned;
  // A misaligned redirect that lands while a fetch is outstanding must first
  // finish the DROP; this remembers that FAULT follows the discarded ack.
  logic        drop_fault_q, drop_fault_d;
`endif

  assign slot_consumed = slot_valid_q & ~PC_lock;
  assign slot_free     = ~slot_valid_q | ~PC_lock;

`ifdef IF_MISALIGN_CHECK_EN
  assign redirect_pc       = PC_target;
  assign target_misaligned = |PC_target[1:0];
  assign redirect_state    = target_misaligned ? FAULT : FETCH;
`else
  assign redirect_pc       = PC_target & 32'hFFFF_FFFC;
  assign redirect_state    = FETCH;
`endif

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    drop_addr_d  = drop_addr_q;
    slot_valid_d = slot_valid_q;
    slot_pc_d    = slot_pc_q;
    slot_inst_d  = slot_inst_q;
    skid_pc_d    = skid_pc_q;
    skid_inst_d  = skid_inst_q;
`ifdef IF_MISALIGN_CHECK_EN
    drop_fault_d = drop_fault_q;
`endif

    if (ControlChange) begin
      // Redirect beats everything, including a held slot.
      slot_valid_d = 1'b0;
      slot_pc_d    = 32'h0;
      slot_inst_d  = NOP_INST;
      skid_pc_d    = 32'h0;
      skid_inst_d  = NOP_INST;
      fetch_pc_d   = redirect_pc;
      case (state_q)
        FETCH: begin
          if (imem_ack) begin
            // Word for the old path arrives with the redirect: drop it.
            state_d = redirect_state;
          end else begin
            // Request cannot be withdrawn; keep its address until the ack.
            state_d     = DROP;
            drop_addr_d = fetch_pc_q;
`ifdef IF_MISALIGN_CHECK_EN
            drop_fault_d = target_misaligned;
`endif
          end
        end
        DROP: begin
          state_d = DROP;
`ifdef IF_MISALIGN_CHECK_EN
          drop_fault_d = target_misaligned;
`endif
        end
        default: state_d = redirect_state;
      endcase
    end else begin
      case (state_q)
        FETCH: begin
          if (imem_ack) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            if (slot_free) begin
              slot_valid_d = 1'b1;
              slot_pc_d    = fetch_pc_q;
              slot_inst_d  = imem_rdata;
            end else begin
              skid_pc_d   = fetch_pc_q;
              skid_inst_d = imem_rdata;
              state_d     = SKID;
            end
          end else if (slot_consumed) begin
            slot_valid_d = 1'b0;
            slot_pc_d    = 32'h0;
            slot_inst_d  = NOP_INST;
          end
        end
        SKID: begin
          // Slot is always full here; the skid drains only when it moves on.
          if (slot_consumed) begin
            slot_valid_d = 1'b1;
            slot_pc_d    = skid_pc_q;
            slot_inst_d  = skid_inst_q;
            state_d      = FETCH;
          end
        end
        DROP: begin
          if (imem_ack) begin
`ifdef IF_MISALIGN_CHECK_EN
            state_d = drop_fault_q ? FAULT : FETCH;
`else
            state_d = FETCH;
`endif
          end
        end
`ifdef IF_MISALIGN_CHECK_EN
        FAULT: state_d = FAULT;
`endif
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= FETCH;
      fetch_pc_q   <= RESET_PC;
      drop_addr_q  <= RESET_PC;
      slot_valid_q <= 1'b0;
      slot_pc_q    <= 32'h0;
      slot_inst_q  <= NOP_INST;
      skid_pc_q    <= 32'h0;
      skid_inst_q  <= NOP_INST;
`ifdef IF_MISALIGN_CHECK_EN
      drop_fault_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      drop_addr_q  <= drop_addr_d;
      slot_valid_q <= slot_valid_d;
      slot_pc_q    <= slot_pc_d;
      slot_inst_q  <= slot_inst_d;
      skid_pc_q    <= skid_pc_d;
      skid_inst_q  <= skid_inst_d;
`ifdef IF_MISALIGN_CHECK_EN
      drop_fault_q <= drop_fault_d;
`endif
    end
  end

  // Request is held low for as long as reset is asserted; it rises from state
  // as soon as reset is released.
  assign imem_req   = rst & ((state_q == FETCH) | (state_q == DROP));
  assign imem_addr  = (state_q == DROP) ? drop_addr_q : fetch_pc_q;

  assign PC_out     = slot_pc_q;
  assign inst_out   = slot_inst_q;
  assign inst_valid = slot_valid_q;

`ifdef IF_MISALIGN_CHECK_EN
  assign fetch_misalign = (state_q == FAULT);
`else
  assign fetch_misalign = 1'b0;
`endif

endmodule
